// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-producer FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int DATA_W      = 8;
    localparam int NUM_SRC     = 2;
    localparam int BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_e;

endpackage

// File: rtl/arb_hold_slot.sv
// One-entry holding buffer between a producer handshake and the arbiter's push.
module arb_hold_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pop,
    output logic              vld,
    output logic [DATA_W-1:0] data
);

    // Handshake: a byte transfers at a rising edge when in_valid & in_ready.
    // The producer must hold in_valid/in_data stable until that edge; ready
    // is high when the slot is empty or its byte is being popped this cycle,
    // so a pop and a capture in one cycle keep the slot full with no bubble.
    assign in_ready = ~vld | pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            vld  <= 1'b1;
            data <= in_data;
        end else if (pop) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with a burst limit sharing the FIFO write port between
// two producers, each buffered by its own one-entry holding slot.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = fifo_arb_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s0_valid,
    input  logic [DATA_W-1:0]  s0_data,
    output logic               s0_ready,
    input  logic               s1_valid,
    input  logic [DATA_W-1:0]  s1_data,
    output logic               s1_ready,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [DATA_W-1:0]  fifo_wdata,
    output logic [NUM_SRC-1:0] grant
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

    arb_state_e             state, state_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic                   last_owner, last_owner_nxt;
    logic                   hold0_vld, hold1_vld;
    logic [DATA_W-1:0]      hold0_data, hold1_data;
    logic                   push0, push1;

    assign push0 = (state == OWN0) & hold0_vld & ~fifo_full;
    assign push1 = (state == OWN1) & hold1_vld & ~fifo_full;

    arb_hold_slot #(.DATA_W(DATA_W)) u_hold0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s0_valid),
        .in_data  (s0_data),
        .in_ready (s0_ready),
        .pop      (push0),
        .vld      (hold0_vld),
        .data     (hold0_data)
    );

    arb_hold_slot #(.DATA_W(DATA_W)) u_hold1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s1_valid),
        .in_data  (s1_data),
        .in_ready (s1_ready),
        .pop      (push1),
        .vld      (hold1_vld),
        .data     (hold1_data)
    );

    // last_owner resets to 1 so that s0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        burst_cnt_nxt  = burst_cnt;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                burst_cnt_nxt = '0;
                if (hold0_vld && hold1_vld) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (hold0_vld) begin
                    state_nxt = OWN0;
                end else if (hold1_vld) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (push0) begin
                    if (burst_cnt == BURST_LAST && hold1_vld) begin
                        state_nxt      = OWN1;
                        burst_cnt_nxt  = '0;
                        last_owner_nxt = 1'b0;
                    end else if (burst_cnt < BURST_LAST) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                end else if (!hold0_vld) begin
                    state_nxt      = hold1_vld ? OWN1 : IDLE;
                    burst_cnt_nxt  = '0;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (push1) begin
                    if (burst_cnt == BURST_LAST && hold0_vld) begin
                        state_nxt      = OWN0;
                        burst_cnt_nxt  = '0;
                        last_owner_nxt = 1'b1;
                    end else if (burst_cnt < BURST_LAST) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                end else if (!hold1_vld) begin
                    state_nxt      = hold0_vld ? OWN0 : IDLE;
                    burst_cnt_nxt  = '0;
                    last_owner_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_wdata = '0;
        case (state)
            OWN0:    fifo_wdata = hold0_data;
            OWN1:    fifo_wdata = hold1_data;
            default: fifo_wdata = '0;
        endcase
    end

    assign fifo_wr = push0 | push1;
    assign grant   = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario tests plus a randomized run checked against per-producer queues.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk, rst;
    logic          s0_valid, s1_valid, s0_ready, s1_ready;
    logic [DW-1:0] s0_data, s1_data, fifo_wdata;
    logic          fifo_full, fifo_wr;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_fail   = 0;

    logic          smp_wr, smp_r0, smp_r1, smp_hs0, smp_hs1, smp_full;
    logic [DW-1:0] smp_wd, smp_d0, smp_d1;
    logic [1:0]    smp_g;
    logic [9:0]    got_q[$];
    logic [DW-1:0] exp_q0[$], exp_q1[$];

    fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_valid   (s0_valid),
        .s0_data    (s0_data),
        .s0_ready   (s0_ready),
        .s1_valid   (s1_valid),
        .s1_data    (s1_data),
        .s1_ready   (s1_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample mid-cycle, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        smp_wr   = fifo_wr;
        smp_wd   = fifo_wdata;
        smp_g    = grant;
        smp_r0   = s0_ready;
        smp_r1   = s1_ready;
        smp_hs0  = s0_valid & s0_ready;
        smp_hs1  = s1_valid & s1_ready;
        smp_d0   = s0_data;
        smp_d1   = s1_data;
        smp_full = fifo_full;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (smp_wr) got_q.push_back({smp_g, smp_wd});
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = '0; s1_data = '0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = '0; s1_data = '0; fifo_full = 1'b1;
        @(negedge clk);
        n_checks++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", fifo_wr); end
        n_checks++; if (fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", fifo_wdata); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_checks++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s0_ready: got %b want 1", s0_ready); end
        n_checks++; if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s1_ready: got %b want 1", s1_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic test_single_byte();
        logic       exp_wr[4];
        logic [1:0] exp_g[4];
        exp_wr = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_g  = '{2'b00, 2'b01, 2'b01, 2'b00};
        apply_reset();
        s0_valid = 1'b1; s0_data = 8'hA5;
        tick();
        n_checks++; if (smp_r0 !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", smp_r0); end
        s0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (smp_wr !== exp_wr[k]) begin n_fail++; $display("FAIL single_wr[%0d]: got %b want %b", k, smp_wr, exp_wr[k]); end
            n_checks++; if (smp_g !== exp_g[k]) begin n_fail++; $display("FAIL single_grant[%0d]: got %b want %b", k, smp_g, exp_g[k]); end
            if (k == 1) begin
                n_checks++; if (smp_wd !== 8'hA5) begin n_fail++; $display("FAIL single_wdata: got %h want a5", smp_wd); end
            end
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp[$];
        logic [DW-1:0] got[$];
        int gcyc[$];
        int a = 0, b = 0, i0 = 0, i1 = 0;
        // Both producers always pending: alternate bursts of MB, s0 first.
        while (a < 10 || b < 10) begin
            for (int k = 0; k < MB && a < 10; k++) begin exp.push_back(8'(a)); a++; end
            for (int k = 0; k < MB && b < 10; k++) begin exp.push_back(8'h80 + 8'(b)); b++; end
        end
        apply_reset();
        for (int c = 0; c < 80 && got.size() < 20; c++) begin
            s0_valid = (i0 < 10); s0_data = 8'(i0);
            s1_valid = (i1 < 10); s1_data = 8'h80 + 8'(i1);
            tick();
            if (smp_hs0) i0++;
            if (smp_hs1) i1++;
            if (smp_wr) begin got.push_back(smp_wd); gcyc.push_back(c); end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        n_checks++; if (got.size() != 20) begin n_fail++; $display("FAIL stream_count: got %0d want 20", got.size()); end
        for (int k = 0; k < got.size() && k < 20; k++) begin
            n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, got[k], exp[k]); end
        end
        if (gcyc.size() >= 18) begin
            n_checks++; if (gcyc[17] - gcyc[0] != 17) begin n_fail++; $display("FAIL stream_rate: 18 pushes span %0d cycles want 17", gcyc[17] - gcyc[0]); end
        end
        drain(4);
    endtask

    task automatic test_s1_only();
        logic [DW-1:0] got[$];
        int gcyc[$];
        int i1 = 0;
        apply_reset();
        for (int c = 0; c < 60 && got.size() < 12; c++) begin
            s1_valid = (i1 < 12); s1_data = 8'hC0 + 8'(i1);
            tick();
            n_checks++; if (smp_r0 !== 1'b1) begin n_fail++; $display("FAIL s1only_s0_ready: got %b want 1", smp_r0); end
            if (smp_hs1) i1++;
            if (smp_wr) begin
                n_checks++; if (smp_g !== 2'b10) begin n_fail++; $display("FAIL s1only_grant: got %b want 10", smp_g); end
                got.push_back(smp_wd); gcyc.push_back(c);
            end
        end
        s1_valid = 1'b0;
        n_checks++; if (got.size() != 12) begin n_fail++; $display("FAIL s1only_count: got %0d want 12", got.size()); end
        for (int k = 0; k < got.size() && k < 12; k++) begin
            n_checks++; if (got[k] !== 8'hC0 + 8'(k)) begin n_fail++; $display("FAIL s1only_data[%0d]: got %h want %h", k, got[k], 8'hC0 + 8'(k)); end
        end
        if (gcyc.size() == 12) begin
            n_checks++; if (gcyc[11] - gcyc[0] != 11) begin n_fail++; $display("FAIL s1only_rate: span %0d want 11", gcyc[11] - gcyc[0]); end
        end
        drain(3);
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] got[$];
        int i0 = 0, full_left = 0;
        apply_reset();
        for (int c = 0; c < 80 && got.size() < 8; c++) begin
            s0_valid  = (i0 < 8); s0_data = 8'h40 + 8'(i0);
            fifo_full = (full_left > 0);
            tick();
            if (smp_full) begin
                full_left--;
                n_checks++; if (smp_wr !== 1'b0) begin n_fail++; $display("FAIL stall_wr: got %b want 0", smp_wr); end
                n_checks++; if (smp_r0 !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", smp_r0); end
            end
            if (smp_hs0) i0++;
            if (smp_wr) begin
                got.push_back(smp_wd);
                if (got.size() == 3) full_left = 5;
            end
        end
        s0_valid = 1'b0; fifo_full = 1'b0;
        n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            n_checks++; if (got[k] !== 8'h40 + 8'(k)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", k, got[k], 8'h40 + 8'(k)); end
        end
        drain(3);
    endtask

    task automatic test_tie();
        logic [9:0] exp[4];
        exp = '{{2'b01, 8'h11}, {2'b10, 8'h22}, {2'b10, 8'h55}, {2'b01, 8'h44}};
        apply_reset();
        s0_valid = 1'b1; s0_data = 8'h11; s1_valid = 1'b1; s1_data = 8'h22;
        tick();
        n_checks++; if (!(smp_hs0 && smp_hs1)) begin n_fail++; $display("FAIL tie_handshake: got %b%b want 11", smp_hs0, smp_hs1); end
        s0_valid = 1'b0; s1_valid = 1'b0;
        drain(8);
        // s0 served alone so it is the most recent owner before the next tie.
        s0_valid = 1'b1; s0_data = 8'h33;
        drain(1);
        s0_valid = 1'b0;
        drain(6);
        n_checks++; if (got_q.size() != 3 || got_q[2] !== {2'b01, 8'h33}) begin n_fail++; $display("FAIL tie_solo: got %0d pushes want 3 ending 133", got_q.size()); end
        void'(got_q.pop_back());
        s0_valid = 1'b1; s0_data = 8'h44; s1_valid = 1'b1; s1_data = 8'h55;
        drain(1);
        s0_valid = 1'b0; s1_valid = 1'b0;
        drain(8);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL tie_count: got %0d want 4", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 4; k++) begin
            n_checks++; if (got_q[k] !== exp[k]) begin n_fail++; $display("FAIL tie_order[%0d]: got %h want %h", k, got_q[k], exp[k]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fifo_full = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h77;
        tick();
        s1_valid = 1'b0;
        tick();
        s0_valid = 1'b1; s0_data = 8'h99;
        tick();
        s0_valid = 1'b0;
        tick();
        n_checks++; if (smp_g !== 2'b10 || smp_r0 !== 1'b0 || smp_r1 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_setup: grant %b ready %b%b want 10 ready 00", smp_g, smp_r0, smp_r1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_wr: got %b want 0", fifo_wr); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL midrst_grant: got %b want 00", grant); end
        n_checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b%b want 11", s0_ready, s1_ready); end
        n_checks++; if (fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_wdata: got %h want 00", fifo_wdata); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_full = 1'b0;
        got_q.delete();
        drain(6);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d pushes want 0", got_q.size()); end
        s0_valid = 1'b1; s0_data = 8'h66;
        drain(1);
        s0_valid = 1'b0;
        drain(6);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== {2'b01, 8'h66}) begin
            n_fail++; $display("FAIL midrst_restart: got %0d pushes want one 166", got_q.size());
        end
    endtask

    task automatic test_random();
        int run_owner = -1, run_len = 0;
        logic occ0, occ1, p0, p1;
        apply_reset();
        exp_q0.delete(); exp_q1.delete();
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                if (!s0_valid && $urandom_range(0, 1) == 1) begin s0_valid = 1'b1; s0_data = 8'($urandom); end
                if (!s1_valid && $urandom_range(0, 1) == 1) begin s1_valid = 1'b1; s1_data = 8'($urandom); end
                fifo_full = ($urandom_range(0, 3) == 0);
            end else begin
                fifo_full = 1'b0;
            end
            tick();
            occ0 = (exp_q0.size() != 0);
            occ1 = (exp_q1.size() != 0);
            p0 = smp_wr && (smp_g == 2'b01);
            p1 = smp_wr && (smp_g == 2'b10);
            n_checks++; if (smp_full && smp_wr) begin n_fail++; $display("FAIL rand_wr_full: cycle %0d wr=1 while full", c); end
            n_checks++; if (smp_r0 !== (!occ0 || p0)) begin n_fail++; $display("FAIL rand_ready0: cycle %0d got %b want %b", c, smp_r0, !occ0 || p0); end
            n_checks++; if (smp_r1 !== (!occ1 || p1)) begin n_fail++; $display("FAIL rand_ready1: cycle %0d got %b want %b", c, smp_r1, !occ1 || p1); end
            if (smp_wr) begin
                n_checks++;
                if (!(p0 || p1)) begin
                    n_fail++; $display("FAIL rand_grant: cycle %0d push with grant %b", c, smp_g);
                end else if ((p0 && !occ0) || (p1 && !occ1)) begin
                    n_fail++; $display("FAIL rand_phantom: cycle %0d push %h from empty producer", c, smp_wd);
                end else if (p0 && smp_wd !== exp_q0[0]) begin
                    n_fail++; $display("FAIL rand_data0: cycle %0d got %h want %h", c, smp_wd, exp_q0[0]);
                end else if (p1 && smp_wd !== exp_q1[0]) begin
                    n_fail++; $display("FAIL rand_data1: cycle %0d got %h want %h", c, smp_wd, exp_q1[0]);
                end
                if (p0 && occ0) void'(exp_q0.pop_front());
                if (p1 && occ1) void'(exp_q1.pop_front());
                if ((p0 && !occ1) || (p1 && !occ0)) run_len = 0;
                else run_len = (run_owner == int'(p1)) ? run_len + 1 : 1;
                run_owner = int'(p1);
                n_checks++; if (run_len > MB) begin n_fail++; $display("FAIL rand_burst: cycle %0d run %0d exceeds %0d", c, run_len, MB); end
            end
            if (smp_hs0) begin exp_q0.push_back(smp_d0); s0_valid = 1'b0; end
            if (smp_hs1) begin exp_q1.push_back(smp_d1); s1_valid = 1'b0; end
        end
        n_checks++; if (s0_valid || s1_valid) begin n_fail++; $display("FAIL rand_accept: offers still pending %b%b want 00", s0_valid, s1_valid); end
        n_checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: left %0d/%0d bytes want 0/0", exp_q0.size(), exp_q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_stream();
        test_s1_only();
        test_full_stall();
        test_tie();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the 8-deep, 8-bit `fifo` between two producers, s0 and s1 (e.g. UART RX command path and counter status path).
- Each producer has a valid/ready handshake into a private 1-entry holding slot.
- A round-robin FSM with burst limit moves held bytes into the FIFO (`fifo_wr`/`fifo_wdata`), respecting `fifo_full` back-pressure.
- Sits directly in front of `fifo.wr`/`fifo.wdata`; consumes `fifo.full`.

Parameters:
- DATA_W, 8, byte width of producer data and FIFO write data
- MAX_BURST, 4, max consecutive pushes granted to one producer while the other has a byte held (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s0_valid  in  1  producer 0 offers `s0_data`
- s0_data  in  DATA_W  producer 0 byte
- s0_ready  out  1  producer 0 byte accepted when `s0_valid & s0_ready` at a rising edge
- s1_valid  in  1  producer 1 offers `s1_data`
- s1_data  in  DATA_W  producer 1 byte
- s1_ready  out  1  producer 1 handshake
- fifo_full  in  1  `full` from the FIFO (registered there)
- fifo_wr  out  1  push strobe to FIFO `wr`
- fifo_wdata  out  DATA_W  byte to FIFO `wdata`
- grant  out  2  one-hot current owner: 01 = s0, 10 = s1, 00 = idle

Behaviour:
- Reset (async, immediate):
  - hold0_vld = hold1_vld = 0; hold data = 0.
  - state = IDLE; burst_cnt = 0; last_owner = 1, so s0 wins the first tie.
  - Outputs: `fifo_wr` = 0, `fifo_wdata` = 0, `grant` = 00, `s0_ready` = `s1_ready` = 1.
- Holding slot i:
  - `si_ready = ~hold_i_vld | push_i`, combinational from registers and `fifo_full`.
  - On `si_valid & si_ready`: hold_i_data <= `si_data`, hold_i_vld <= 1.
  - If push_i and no capture: hold_i_vld <= 0.
  - Push and capture in the same cycle: the new byte replaces the old one, vld stays 1, no bubble.
- Push: `push_i = (state == OWNi) & hold_i_vld & ~fifo_full`.
  - `fifo_wr = push_0 | push_1`.
  - `fifo_wdata` = hold data of the owner, 0 in IDLE.
  - Never assert `fifo_wr` while `fifo_full` = 1.
- FSM states: IDLE, OWN0, OWN1. `grant` decodes the state.
- IDLE:
  - Both holds valid: go to OWN(~last_owner).
  - Otherwise go to OWN of the valid one.
  - Neither valid: stay IDLE.
  - burst_cnt <= 0.
- OWNi:
  - push_i and burst_cnt == MAX_BURST-1 and other hold valid: go to OWNother, burst_cnt <= 0, last_owner <= i.
  - push_i otherwise: stay; burst_cnt <= min(burst_cnt+1, MAX_BURST-1).
  - ~hold_i_vld: go to OWNother if its hold is valid, else IDLE; burst_cnt <= 0; last_owner <= i.
  - hold_i_vld & `fifo_full`: stall. State, burst_cnt and hold are all unchanged.
- Latency:
  - Handshake at edge N while IDLE: first `fifo_wr` in cycle N+2.
  - When already owner: cycle N+1.
  - Sustained throughput: 1 byte/cycle aggregate.
- Ordering:
  - Bytes from one producer reach the FIFO in handshake order.
  - No byte is lost or duplicated except on reset.
- Reset mid-operation: held bytes are discarded. The FIFO's own contents are the FIFO's concern.
- Width: burst_cnt is 4 bits, saturating. No wrap.

Decomposition:
- Package `fifo_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e`
  - localparams DATA_W = 8, NUM_SRC = 2, BURST_CNT_W = 4
- Sub-module `arb_hold_slot`:
  - 1-entry buffer with valid/ready in, vld/data/pop out.
  - Instantiated twice.
- FSM, counter and muxing stay in the top module.

Test Plan:
- Reset release, s0 single byte 0xA5 (`s0_valid` for 1 cycle):
  - `s0_ready`=1.
  - `fifo_wr`=1 with `fifo_wdata`=0xA5 exactly 2 cycles after the handshake edge.
  - `grant` goes 01 then 00.
- s0 and s1 stream continuously, s0 bytes 0x00..0x09, s1 bytes 0x80..0x89, MAX_BURST=4, `fifo_full`=0:
  - FIFO sees 00,01,02,03,80,81,82,83,04,05,...
  - One push per cycle once ownership starts.
- Only s1 streams 12 bytes:
  - All 12 are pushed back-to-back under OWN1. Burst limit never forces a switch.
  - `s0_ready` stays 1.
- `fifo_full` asserted for 5 cycles during an s0 stream:
  - `fifo_wr`=0 throughout; `s0_ready`=0 while the hold is occupied.
  - After release, the stalled byte is pushed first; no loss or duplication.
- Simultaneous first requests from IDLE after reset:
  - s0 granted first (0x11), then s1 (0x22).
  - Next tie after OWN0 is served goes to s1.
- `rst` asserted while both holds are valid and state OWN1:
  - Immediately `fifo_wr`=0, `grant`=00, both readies=1.
  - Post-reset traffic restarts cleanly with no stale byte pushed.
